if_stage: RTL and testbench

Instruction-fetch stage for the in-order RISC-V pipeline. It owns the PC register, the instruction-memory request/response handshake and the IF/ID pipeline register. It is the consumer of the `hold`/`jump` pair driven by `ctrl`: it freezes on hold, flushes and redirects on jump, and buffers any fetch response that lands while the pipeline is frozen.

---
 rtl/if_stage_pkg.sv | 31 +++
 rtl/if_skid_buf.sv | 55 +++++
 rtl/if_stage.sv | 167 ++++++++++++++++
 tb/tb_if_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage shared types: bus widths, fetch FSM states, IF/ID bundle.
// Imported by if_stage and if_skid_buf.
package if_stage_pkg;

  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;

  typedef enum logic [1:0] {
    IF_REQ,
    IF_WAIT,
    IF_DISCARD
  } IfState;

  // addi x0,x0,0
  localparam InstBus INST_NOP = 32'h0000_0013;

  typedef struct packed {
    InstBus     inst;
    InstAddrBus addr;
    logic       valid;
  } if_id_t;

  function automatic if_id_t if_id_bubble(input InstBus nop);
    if_id_t b;
    b.inst  = nop;
    b.addr  = '0;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry buffer for a fetch response that lands
// while IF/ID is frozen. Priority: clear, then load, then pop.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       pop_i,
  input  logic       clear_i,
  input  InstBus     data_i,
  input  InstAddrBus addr_i,
  output logic       valid_o,
  output InstBus     data_o,
  output InstAddrBus addr_o
);

  logic       valid_q, valid_d;
  InstBus     data_q, data_d;
  InstAddrBus addr_q, addr_d;

  // next-state for the single entry
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      addr_d  = addr_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  // entry register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: PC, imem handshake and IF/ID register; obeys hold/jump.
// Optional IF_PERF_CNT_EN adds hold/flush cycle counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter InstAddrBus RESET_PC = 32'h0000_0000,
  parameter InstBus     NOP_INST = INST_NOP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold_i,
  input  logic       jump_i,
  input  InstAddrBus jump_addr_i,
  output logic       imem_req_o,
  output InstAddrBus imem_addr_o,
  input  logic       imem_gnt_i,
  input  logic       imem_rvalid_i,
  input  InstBus     imem_rdata_i,
  output InstBus     inst_o,
  output InstAddrBus inst_addr_o,
  output logic       inst_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] hold_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  IfState     state_q, state_d;
  InstAddrBus pc_q, pc_d;
  InstAddrBus req_addr_q, req_addr_d;
  if_id_t     ifid_q, ifid_d;

  logic       req;
  logic       fire;
  logic       deliver;

  logic       skid_valid;
  InstBus     skid_data;
  InstAddrBus skid_addr;
  logic       skid_load;
  logic       skid_pop;
  logic       skid_clear;

  if_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_load),
    .pop_i  (skid_pop),
    .clear_i(skid_clear),
    .data_i (imem_rdata_i),
    .addr_i (req_addr_q),
    .valid_o(skid_valid),
    .data_o (skid_data),
    .addr_o (skid_addr)
  );

  // fetch FSM: request decode and next state
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    deliver = 1'b0;
    unique case (state_q)
      IF_REQ: begin
        req = !skid_valid && !jump_i && !rst;
        if (req && imem_gnt_i) begin
          state_d = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (jump_i) begin
          state_d = imem_rvalid_i ? IF_REQ : IF_DISCARD;
        end else if (imem_rvalid_i) begin
          deliver = 1'b1;
          state_d = IF_REQ;
        end
      end
      IF_DISCARD: begin
        if (imem_rvalid_i) begin
          state_d = IF_REQ;
        end
      end
      default: state_d = IF_REQ;
    endcase
  end

  assign fire        = req && imem_gnt_i;
  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;

  // PC and outstanding-request address
  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    if (jump_i) begin
      pc_d = jump_addr_i;
    end else if (fire) begin
      pc_d       = pc_q + 32'd4;
      req_addr_d = pc_q;
    end
  end

  // IF/ID update and skid control
  always_comb begin
    ifid_d     = ifid_q;
    skid_load  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;
    if (jump_i) begin
      ifid_d     = if_id_bubble(NOP_INST);
      skid_clear = 1'b1;
    end else if (hold_i) begin
      skid_load = deliver;
    end else if (skid_valid) begin
      ifid_d.inst  = skid_data;
      ifid_d.addr  = skid_addr;
      ifid_d.valid = 1'b1;
      skid_pop     = 1'b1;
      skid_load    = deliver;
    end else if (deliver) begin
      ifid_d.inst  = imem_rdata_i;
      ifid_d.addr  = req_addr_q;
      ifid_d.valid = 1'b1;
    end else begin
      ifid_d = if_id_bubble(NOP_INST);
    end
  end

  // state, PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IF_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ifid_q     <= if_id_bubble(NOP_INST);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ifid_q     <= ifid_d;
    end
  end

  assign inst_o       = ifid_q.inst;
  assign inst_addr_o  = ifid_q.addr;
  assign inst_valid_o = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] hold_cnt_q;
  logic [31:0] flush_cnt_q;

  // cycle counters for hold and jump
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hold_i) hold_cnt_q <= hold_cnt_q + 32'd1;
      if (jump_i) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hold_cnt_o  = hold_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed cycle table against if_stage with a
// stallable one-outstanding instruction memory model.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        jump;
  logic [31:0] jaddr;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] inst;
  logic [31:0] iaddr;
  logic        ivalid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] hold_cnt;
  logic [31:0] flush_cnt;
`endif

  logic        stall;
  logic        pend;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .hold_i       (hold),
    .jump_i       (jump),
    .jump_addr_i  (jaddr),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_gnt_i   (gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .inst_o       (inst),
    .inst_addr_o  (iaddr),
    .inst_valid_o (ivalid)
`ifdef IF_PERF_CNT_EN
    ,
    .hold_cnt_o   (hold_cnt),
    .flush_cnt_o  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h0050_0093;
      32'h4:   mem_word = 32'h00A0_0113;
      default: mem_word = {a[23:0], 8'h13};
    endcase
  endfunction

  assign gnt    = 1'b1;
  assign rvalid = pend && !stall;

  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (req && gnt) begin
      pend  <= 1'b1;
      rdata <= mem_word(addr);
    end else if (rvalid) begin
      pend <= 1'b0;
    end
  end

  typedef struct {
    bit          rst;
    bit          hold;
    bit          jump;
    logic [31:0] jaddr;
    bit          stall;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] inst;
    bit          ck_ia;
    logic [31:0] iaddr;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(
    input bit r, input bit h, input bit j,
    input logic [31:0] ja, input bit s,
    input bit q, input logic [31:0] a,
    input bit v, input logic [31:0] ins,
    input bit c, input logic [31:0] ia);
    vec_t t;
    t.rst = r; t.hold = h; t.jump = j;
    t.jaddr = ja; t.stall = s;
    t.req = q; t.addr = a; t.valid = v;
    t.inst = ins; t.ck_ia = c; t.iaddr = ia;
    return t;
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h",
               nm, row, act, exp);
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    int n;
    rst = 1'b1; hold = 1'b0; jump = 1'b0;
    jaddr = '0; stall = 1'b0;

    tbl[0]  = mk(1,0,0,0,0, 0,32'h0,  0,NOP,1,0);
    tbl[1]  = mk(0,0,0,0,0, 1,32'h0,  0,NOP,0,0);
    tbl[2]  = mk(0,0,0,0,0, 0,32'h4,  0,NOP,0,0);
    tbl[3]  = mk(0,0,0,0,0, 1,32'h4,  1,32'h0050_0093,1,32'h0);
    tbl[4]  = mk(0,0,0,0,0, 0,32'h8,  0,NOP,0,0);
    tbl[5]  = mk(0,0,0,0,0, 1,32'h8,  1,32'h00A0_0113,1,32'h4);
    tbl[6]  = mk(0,1,0,0,0, 0,32'hC,  0,NOP,0,0);
    tbl[7]  = mk(0,1,0,0,0, 0,32'hC,  0,NOP,0,0);
    tbl[8]  = mk(0,1,0,0,0, 0,32'hC,  0,NOP,0,0);
    tbl[9]  = mk(0,0,0,0,0, 0,32'hC,  0,NOP,0,0);
    tbl[10] = mk(0,0,0,0,0, 1,32'hC,  1,32'h0000_0813,1,32'h8);
    tbl[11] = mk(0,0,1,32'h100,1, 0,32'h10, 0,NOP,0,0);
    tbl[12] = mk(0,0,0,0,0, 0,32'h100, 0,NOP,0,0);
    tbl[13] = mk(0,0,0,0,0, 1,32'h100, 0,NOP,0,0);
    tbl[14] = mk(0,0,0,0,0, 0,32'h104, 0,NOP,0,0);
    tbl[15] = mk(0,1,0,0,0, 1,32'h104,
                 1,32'h0001_0013,1,32'h100);
    tbl[16] = mk(0,1,0,0,0, 0,32'h108,
                 1,32'h0001_0013,1,32'h100);
    tbl[17] = mk(0,1,0,0,0, 0,32'h108,
                 1,32'h0001_0013,1,32'h100);
    tbl[18] = mk(0,1,1,32'hFFFF_FFFC,0, 0,32'h108,
                 1,32'h0001_0013,1,32'h100);
    tbl[19] = mk(0,0,0,0,0, 1,32'hFFFF_FFFC, 0,NOP,0,0);
    tbl[20] = mk(0,0,0,0,0, 0,32'h0, 0,NOP,0,0);
    tbl[21] = mk(0,0,0,0,0, 1,32'h0,
                 1,32'hFFFF_FC13,1,32'hFFFF_FFFC);
    tbl[22] = mk(0,0,1,32'h40,0, 0,32'h4, 0,NOP,0,0);
    tbl[23] = mk(0,0,0,0,0, 1,32'h40, 0,NOP,0,0);
    tbl[24] = mk(0,0,0,0,0, 0,32'h44, 0,NOP,0,0);
    tbl[25] = mk(0,0,0,0,0, 1,32'h44,
                 1,32'h0000_4013,1,32'h40);
    tbl[26] = mk(1,0,0,0,0, 0,32'h48, 0,NOP,0,0);
    tbl[27] = mk(0,0,0,0,0, 1,32'h0, 0,NOP,1,32'h0);
    tbl[28] = mk(0,0,0,0,0, 0,32'h4, 0,NOP,0,0);
    tbl[29] = mk(0,0,0,0,0, 1,32'h4,
                 1,32'h0050_0093,1,32'h0);

    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      rst   = tbl[i].rst;
      hold  = tbl[i].hold;
      jump  = tbl[i].jump;
      jaddr = tbl[i].jaddr;
      stall = tbl[i].stall;
      @(negedge clk);
      chk("imem_req", i, {31'b0, req}, {31'b0, tbl[i].req});
      chk("imem_addr", i, addr, tbl[i].addr);
      chk("inst_valid", i, {31'b0, ivalid},
          {31'b0, tbl[i].valid});
      chk("inst", i, inst, tbl[i].inst);
      if (tbl[i].ck_ia) chk("inst_addr", i, iaddr, tbl[i].iaddr);
    end

`ifdef IF_PERF_CNT_EN
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      rst   = 1'b0;
      hold  = (i < 5);
      jump  = (i >= 5);
      jaddr = 32'h200;
    end
    @(posedge clk);
    #1;
    hold = 1'b0;
    jump = 1'b0;
    @(negedge clk);
    chk("hold_cnt", 100, hold_cnt, 32'd5);
    chk("flush_cnt", 100, flush_cnt, 32'd2);
`endif

    @(posedge clk);
    #1;
    rst = 1'b1; hold = 1'b0; jump = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
`ifdef IF_PERF_CNT_EN
    chk("hold_cnt_rst", 101, hold_cnt, 32'd0);
    chk("flush_cnt_rst", 101, flush_cnt, 32'd0);
`endif
    n = 0;
    while (!ivalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!ivalid) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got no valid want valid");
    end else begin
      chk("latency", 102, n, 32'd2);
      chk("first_inst", 102, inst, 32'h0050_0093);
      chk("first_addr", 102, iaddr, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
